// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC phase generator: phase width, quadrant codes,
// inverse CORDIC gain and the burst controller state encoding.
package cordic_pkg;

    localparam int PHASE_W = 32;

    // Top two phase bits select the quadrant of the 2*pi circle.
    localparam logic [1:0] QUAD_I   = 2'b00;
    localparam logic [1:0] QUAD_II  = 2'b01;
    localparam logic [1:0] QUAD_III = 2'b10;
    localparam logic [1:0] QUAD_IV  = 2'b11;

    // 0.607253 in Q1.31: the factor that cancels the CORDIC rotation gain.
    localparam logic [31:0] CORDIC_GAIN_INV = 32'd1304065888;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] phase0;
        logic [PHASE_W-1:0] fcw;
        logic [PHASE_W-1:0] step;
    } phase_cfg_t;

    function automatic logic [1:0] quadrant(input logic [PHASE_W-1:0] phase);
        return phase[PHASE_W-1 -: 2];
    endfunction

endpackage

// File: rtl/cordic_valid_delay.sv
// Shift register that delays the sample-valid flag by the CORDIC pipeline depth so that
// the consumer sees it aligned with Xout/Yout.
module cordic_valid_delay #(
    parameter int DEPTH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    // NOTE: this delay line is reset on purpose: stale taps would emit phantom res_valid
    // pulses for samples discarded by a mid-burst reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps <= (taps << 1) | DEPTH'(din);
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Burst phase generator feeding a pipelined sine/cosine CORDIC: tone and linear-chirp
// phase sequences, gain-compensated seeds and a valid flag matched to the CORDIC latency.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int C_WIDTH = 16,
    parameter int AMPL    = 19898,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [PHASE_W-1:0]        cfg_phase0,
    input  logic [PHASE_W-1:0]        cfg_fcw,
    input  logic [PHASE_W-1:0]        cfg_step,
    input  logic [CNT_W-1:0]          cfg_count,
    input  logic                      start,
    input  logic                      stop,
    output logic                      busy,
    output logic [PHASE_W-1:0]        angle,
    output logic signed [C_WIDTH-1:0] xin,
    output logic signed [C_WIDTH-1:0] yin,
    output logic                      angle_valid,
    output logic                      res_valid,
    output logic                      done
);

    localparam int                        DRAIN_W    = $clog2(C_WIDTH) + 1;
    localparam logic [DRAIN_W-1:0]        DRAIN_LOAD = DRAIN_W'(C_WIDTH - 1);
    localparam logic signed [C_WIDTH-1:0] XIN_SEED   = C_WIDTH'(AMPL);

    state_t             state;
    phase_cfg_t         cfg_q;
    logic [CNT_W-1:0]   count_q;
    logic [PHASE_W-1:0] phase_acc;
    logic [PHASE_W-1:0] freq_acc;
    logic [CNT_W-1:0]   remain;
    logic [DRAIN_W-1:0] drain_cnt;

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values; phase_acc and freq_acc rely on that to update in lockstep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cfg_q       <= '0;
            count_q     <= '0;
            phase_acc   <= '0;
            freq_acc    <= '0;
            remain      <= '0;
            drain_cnt   <= '0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            angle       <= '0;
            xin         <= '0;
            angle_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            angle_valid <= 1'b0;
            xin         <= '0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        cfg_q.phase0 <= cfg_phase0;
                        cfg_q.fcw    <= cfg_fcw;
                        cfg_q.step   <= cfg_step;
                        count_q      <= cfg_count;
                        cfg_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ARMED;
                    end
                end

                ARMED: begin
                    if (stop) begin
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (start) begin
                        phase_acc <= cfg_q.phase0;
                        freq_acc  <= cfg_q.fcw;
                        remain    <= count_q;
                        state     <= RUN;
                    end
                end

                RUN: begin
                    angle       <= phase_acc;
                    xin         <= XIN_SEED;
                    angle_valid <= 1'b1;
                    phase_acc   <= phase_acc + freq_acc;
                    freq_acc    <= freq_acc + cfg_q.step;
                    if (count_q != '0) begin
                        remain <= remain - CNT_W'(1);
                    end
                    // A stop still lets this cycle's sample out; it becomes the last one.
                    if (stop || (count_q != '0 && remain == CNT_W'(1))) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (done) begin
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (drain_cnt == '0) begin
                        done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign yin = '0;

    cordic_valid_delay #(
        .DEPTH(C_WIDTH)
    ) u_valid_delay (
        .clock(clock),
        .reset(reset),
        .din  (angle_valid),
        .dout (res_valid)
    );

endmodule
